// File: rtl/pet_vram_pkg.sv
// Shared definitions for the PET VRAM writer.
// Holds the writer state encoding, the VRAM address/data widths and the
// default clear character and screen size used as parameter defaults.
package pet_vram_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] DEF_CLEAR_CHAR  = 8'h20;
   localparam int                DEF_SCREEN_SIZE = 1000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_e;

endpackage

// File: rtl/pet_vram_fifo.sv
// Synchronous FIFO holding pending CPU writes for the PET VRAM writer.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset (control only)
//   push_i, din_i  - write request and data; ignored while full
//   pop_i, dout_o  - read request; dout_o shows the head entry (show-ahead)
//   full_o, empty_o, count_o - status derived from the registered occupancy
module pet_vram_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 19
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   // Full/empty come from the registered count, so a pop in the same cycle
   // never makes room for a push.
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/pet_vram_writer.sv
// PET VRAM writer: queues CPU screen writes and replays them to VRAM, and
// fills the screen with CLEAR_CHAR on request (after queued writes land).
// Optional macro VRAM_RETRACE_GATE_EN: when defined, VRAM writes are only
// issued on edges where video_on=0; otherwise every edge is a write slot.
// Ports:
//   clk, reset_n                        - clock, async active-low reset
//   ce_cpu, cpu_we, cpu_addr, cpu_data  - CPU write port
//   cpu_full, overflow                  - queue full, sticky dropped-write flag
//   clear_req, clear_busy               - clear request / clear in progress
//   video_on                            - active display scan indicator
//   vram_addr, vram_data, vram_we       - registered VRAM write port
module pet_vram_writer
   import pet_vram_pkg::*;
#(
   parameter int                FIFO_DEPTH  = 8,
   parameter logic [DATA_W-1:0] CLEAR_CHAR  = DEF_CLEAR_CHAR,
   parameter int                SCREEN_SIZE = DEF_SCREEN_SIZE
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce_cpu,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_full,
   output logic              overflow,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic              video_on,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_data,
   output logic              vram_we
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_SIZE - 1);

   state_e                     state_q;
   logic                       pend_q;
   logic                       busy_q;
   logic                       overflow_q;
   logic [ADDR_W-1:0]          clr_cnt_q;
   logic [ADDR_W-1:0]          vram_addr_q;
   logic [DATA_W-1:0]          vram_data_q;
   logic                       vram_we_q;

   logic                       slot;
   logic                       wr_req;
   logic                       pop;
   logic                       clear_acc;
   logic                       has_entries;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [CNT_W-1:0]           fifo_count;
   logic [ADDR_W+DATA_W-1:0]   fifo_dout;

`ifdef VRAM_RETRACE_GATE_EN
   assign slot = ~video_on;
`else
   logic unused_video_on;
   assign unused_video_on = video_on;
   assign slot            = 1'b1;
`endif

   assign wr_req      = ce_cpu & cpu_we;
   assign has_entries = (fifo_count != '0);
   assign pop         = (state_q == DRAIN) & slot & ~fifo_empty;
   // A new clear is only taken when none is pending or running.
   assign clear_acc   = clear_req & ~pend_q & (state_q != CLEAR);

   pet_vram_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (wr_req),
      .pop_i   (pop),
      .din_i   ({cpu_addr, cpu_data}),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pend_q      <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
         clr_cnt_q   <= '0;
         vram_addr_q <= '0;
         vram_data_q <= '0;
         vram_we_q   <= 1'b0;
      end else begin
         vram_we_q <= 1'b0;
         if (wr_req && fifo_full) overflow_q <= 1'b1;
         if (clear_acc) begin
            pend_q <= 1'b1;
            busy_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               // Queued writes always go before a pending clear.
               if (has_entries) begin
                  state_q <= DRAIN;
               end else if (pend_q) begin
                  state_q <= CLEAR;
                  pend_q  <= 1'b0;
               end
            end
            DRAIN: begin
               if (pop) begin
                  vram_we_q   <= 1'b1;
                  vram_addr_q <= fifo_dout[DATA_W +: ADDR_W];
                  vram_data_q <= fifo_dout[DATA_W-1:0];
               end else if (!has_entries) begin
                  if (pend_q) begin
                     state_q <= CLEAR;
                     pend_q  <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            CLEAR: begin
               if (slot) begin
                  vram_we_q   <= 1'b1;
                  vram_addr_q <= clr_cnt_q;
                  vram_data_q <= CLEAR_CHAR;
                  if (clr_cnt_q == LAST_ADDR) begin
                     state_q   <= IDLE;
                     clr_cnt_q <= '0;
                     busy_q    <= 1'b0;
                  end else begin
                     clr_cnt_q <= clr_cnt_q + 11'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_full   = fifo_full;
   assign overflow   = overflow_q;
   assign clear_busy = busy_q;
   assign vram_addr  = vram_addr_q;
   assign vram_data  = vram_data_q;
   assign vram_we    = vram_we_q;

endmodule

// File: tb/tb_pet_vram_writer.sv
// Directed bench for pet_vram_writer: every VRAM write pulse is logged at
// the falling clock edge and compared against hand-computed expectations.
module tb_pet_vram_writer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce_cpu;
   logic        cpu_we;
   logic [10:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_full;
   logic        overflow;
   logic        clear_req;
   logic        clear_busy;
   logic        video_on;
   logic [10:0] vram_addr;
   logic [7:0]  vram_data;
   logic        vram_we;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   typedef struct {
      logic [10:0] a;
      logic [7:0]  d;
      logic        b;
      int          c;
   } wr_t;
   wr_t log_q[$];

   pet_vram_writer #(
      .FIFO_DEPTH  (8),
      .CLEAR_CHAR  (8'h20),
      .SCREEN_SIZE (1000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce_cpu     (ce_cpu),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cpu_full   (cpu_full),
      .overflow   (overflow),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .video_on   (video_on),
      .vram_addr  (vram_addr),
      .vram_data  (vram_data),
      .vram_we    (vram_we)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vram_we === 1'b1) log_q.push_back('{vram_addr, vram_data, clear_busy, cyc});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
      step();
      ce_cpu   = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = a;
      cpu_data = d;
   endtask

   task automatic cpu_idle();
      step();
      cpu_we = 1'b0;
   endtask

   task automatic pulse_clear();
      step();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
   endtask

   task automatic wait_log(input string tag, input int n, input int budget);
      int k = 0;
      while (log_q.size() < n && k < budget) begin
         step();
         k++;
      end
      chk(tag, log_q.size(), n);
   endtask

   initial begin
      int errs;
      int base;

      ce_cpu    = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_data  = '0;
      clear_req = 1'b0;
      video_on  = 1'b0;
      reset_n   = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_we",    vram_we,    0);
      chk("rst_addr",  vram_addr,  0);
      chk("rst_data",  vram_data,  0);
      chk("rst_full",  cpu_full,   0);
      chk("rst_ovf",   overflow,   0);
      chk("rst_busy",  clear_busy, 0);
      repeat (2) step();
      reset_n = 1'b1;
      repeat (2) step();

      // Three CPU writes drain in order as back-to-back pulses.
      log_q.delete();
      cpu_write(11'h000, 8'h41);
      cpu_write(11'h001, 8'h42);
      cpu_write(11'h3E7, 8'h43);
      cpu_idle();
      wait_log("w3_count", 3, 20);
      if (log_q.size() == 3) begin
         chk("w3_a0", {log_q[0].a, log_q[0].d}, {11'h000, 8'h41});
         chk("w3_a1", {log_q[1].a, log_q[1].d}, {11'h001, 8'h42});
         chk("w3_a2", {log_q[2].a, log_q[2].d}, {11'h3E7, 8'h43});
         chk("w3_consec", log_q[2].c - log_q[0].c, 2);
      end

`ifdef VRAM_RETRACE_GATE_EN
      // A queued write waits for video_on to fall, then issues on the next edge.
      log_q.delete();
      step();
      video_on = 1'b1;
      cpu_write(11'h123, 8'h55);
      cpu_idle();
      repeat (5) step();
      chk("gate_hold", log_q.size(), 0);
      chk("gate_we0",  vram_we, 0);
      video_on = 1'b0;
      step();
      chk("gate_release", log_q.size(), 1);
      if (log_q.size() == 1) chk("gate_pair", {log_q[0].a, log_q[0].d}, {11'h123, 8'h55});
      repeat (2) step();
`endif

      // Two queued writes, then a clear: writes land first, then 0..999.
      log_q.delete();
      cpu_write(11'h010, 8'hA1);
      cpu_write(11'h011, 8'hA2);
      cpu_idle();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      chk("clr_busy_hi", clear_busy, 1);
      wait_log("clr_count", 1002, 1200);
      if (log_q.size() == 1002) begin
         chk("clr_w0", {log_q[0].a, log_q[0].d}, {11'h010, 8'hA1});
         chk("clr_w1", {log_q[1].a, log_q[1].d}, {11'h011, 8'hA2});
         errs = 0;
         for (int i = 0; i < 1000; i++) begin
            if (log_q[i+2].a !== 11'(i) || log_q[i+2].d !== 8'h20) errs++;
         end
         chk("clr_seq_errs", errs, 0);
         chk("clr_busy_998", log_q[1000].b, 1);
         chk("clr_busy_999", log_q[1001].b, 0);
      end
      repeat (5) step();
      chk("clr_no_extra", log_q.size(), 1002);

      // Writes during a clear: queue fills, 9th dropped, extra clear_req
      // ignored, queued writes issue right after address 999.
      log_q.delete();
      pulse_clear();
      wait_log("ovf_clr_start", 5, 20);
      for (int i = 0; i < 9; i++) begin
         step();
         if (i == 8) begin
            chk("ovf_full8", cpu_full, 1);
            chk("ovf_pre",   overflow, 0);
         end
         ce_cpu   = 1'b1;
         cpu_we   = 1'b1;
         cpu_addr = 11'h100 + 11'(i);
         cpu_data = 8'h80 + 8'(i);
      end
      cpu_idle();
      chk("ovf_set", overflow, 1);
      pulse_clear();
      wait_log("ovf_count", 1008, 1300);
      if (log_q.size() >= 1008) begin
         chk("ovf_last_clr", {log_q[999].a, log_q[999].d}, {11'd999, 8'h20});
         errs = 0;
         for (int i = 0; i < 8; i++) begin
            if (log_q[1000+i].a !== 11'h100 + 11'(i) || log_q[1000+i].d !== 8'h80 + 8'(i)) errs++;
         end
         chk("ovf_drain_errs", errs, 0);
      end
      repeat (30) step();
      chk("ovf_no_extra", log_q.size(), 1008);
      chk("ovf_busy_lo",  clear_busy, 0);
      chk("ovf_sticky",   overflow, 1);

      // Reset in the middle of a clear abandons it.
      log_q.delete();
      pulse_clear();
      begin
         int k = 0;
         while (!(log_q.size() > 0 && log_q[log_q.size()-1].a == 11'd500) && k < 1200) begin
            step();
            k++;
         end
         chk("mid_reach500", log_q.size(), 501);
      end
      reset_n = 1'b0;
      #1;
      chk("mid_we",   vram_we,    0);
      chk("mid_addr", vram_addr,  0);
      chk("mid_data", vram_data,  0);
      chk("mid_ovf",  overflow,   0);
      chk("mid_busy", clear_busy, 0);
      chk("mid_full", cpu_full,   0);
      step();
      reset_n = 1'b1;
      base = log_q.size();
      repeat (40) step();
      chk("mid_no_more", log_q.size(), base);
      chk("mid_busy_after", clear_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
